// File: rtl/dp_pkg.sv
// Shared defaults and ALU opcode encodings for the register-file/ALU datapath slice.
package dp_pkg;

    localparam int DP_DATA_W = 32;
    localparam int DP_ADDR_W = 5;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_SLL = 4'd4;
    localparam logic [3:0] OP_SRL = 4'd5;
    localparam logic [3:0] OP_SRA = 4'd6;
    localparam logic [3:0] OP_SGT = 4'd7;
    localparam logic [3:0] OP_SLT = 4'd8;

endpackage

// File: rtl/dp_regfile.sv
// Register file: async-reset storage, two combinational read ports, one
// synchronous write port; register 0 optionally hardwired to zero.
module dp_regfile
    import dp_pkg::*;
#(
    parameter int DATA_W      = DP_DATA_W,
    parameter int ADDR_W      = DP_ADDR_W,
    parameter bit HARDWIRE_R0 = 1'b1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              WriteEnb,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [NREGS];
    logic              w_wr_en;

    // Writes to r0 are dropped entirely when it is hardwired.
    assign w_wr_en = WriteEnb && !(HARDWIRE_R0 && (WriteReg == '0));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[WriteReg] <= WriteData;
        end
    end

    assign ReadData1 = (HARDWIRE_R0 && (ReadReg1 == '0)) ? '0 : r_mem[ReadReg1];
    assign ReadData2 = (HARDWIRE_R0 && (ReadReg2 == '0)) ? '0 : r_mem[ReadReg2];

endmodule

// File: rtl/regfile_alu_datapath.sv
// Single-cycle execution slice: register file feeding a combinational ALU,
// with a write-back mux choosing ALU result or external data.
module regfile_alu_datapath
    import dp_pkg::*;
#(
    parameter int DATA_W      = DP_DATA_W,
    parameter int ADDR_W      = DP_ADDR_W,
    parameter bit HARDWIRE_R0 = 1'b1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              WriteEnb,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [3:0]        AluOp,
    input  logic [4:0]        Shamt,
    input  logic              MuxCtrl,
    input  logic [DATA_W-1:0] ExtData,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] Result,
    output logic              OverFlow,
    output logic [DATA_W-1:0] WriteData
);

    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;
    logic              w_ov_add;
    logic              w_ov_sub;

    dp_regfile #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .HARDWIRE_R0 (HARDWIRE_R0)
    ) u_regfile (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .WriteEnb  (WriteEnb),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .ReadData1 (w_a),
        .ReadData2 (w_b)
    );

    assign ReadData1 = w_a;
    assign ReadData2 = w_b;

    assign w_sum  = w_a + w_b;
    assign w_diff = w_a - w_b;

    // Signed overflow from operand and result sign bits.
    assign w_ov_add = (w_a[DATA_W-1] == w_b[DATA_W-1]) && (w_sum[DATA_W-1]  != w_a[DATA_W-1]);
    assign w_ov_sub = (w_a[DATA_W-1] != w_b[DATA_W-1]) && (w_diff[DATA_W-1] != w_a[DATA_W-1]);

    always_comb begin
        Result   = '0;
        OverFlow = 1'b0;
        case (AluOp)
            OP_ADD: begin
                Result   = w_sum;
                OverFlow = w_ov_add;
            end
            OP_SUB: begin
                Result   = w_diff;
                OverFlow = w_ov_sub;
            end
            OP_AND: Result = w_a & w_b;
            OP_OR:  Result = w_a | w_b;
            OP_SLL: Result = w_a << Shamt;
            OP_SRL: Result = w_a >> Shamt;
            OP_SRA: Result = $unsigned($signed(w_a) >>> Shamt);
            OP_SGT: Result = {{(DATA_W-1){1'b0}}, ($signed(w_a) > $signed(w_b))};
            OP_SLT: Result = {{(DATA_W-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
            default: begin
                Result   = '0;
                OverFlow = 1'b0;
            end
        endcase
    end

    // The write port is registered, so feeding Result back here forms no loop.
    assign WriteData = MuxCtrl ? Result : ExtData;

endmodule

// File: tb/tb_regfile_alu_datapath.sv
// Directed bench for regfile_alu_datapath with hand-computed expected values.
module tb_regfile_alu_datapath;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        WriteEnb;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [4:0]  WriteReg;
    logic [3:0]  AluOp;
    logic [4:0]  Shamt;
    logic        MuxCtrl;
    logic [31:0] ExtData;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [31:0] Result;
    logic        OverFlow;
    logic [31:0] WriteData;

    int n_total = 0;
    int n_bad   = 0;

    regfile_alu_datapath dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .WriteEnb  (WriteEnb),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .WriteReg  (WriteReg),
        .AluOp     (AluOp),
        .Shamt     (Shamt),
        .MuxCtrl   (MuxCtrl),
        .ExtData   (ExtData),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2),
        .Result    (Result),
        .OverFlow  (OverFlow),
        .WriteData (WriteData)
    );

    // clock
    always #5 Clk = ~Clk;

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: obs=0x%08h exp=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive inputs just after the falling edge, write on the next rising edge.
    task automatic write_ext(input logic [4:0] addr, input logic [31:0] data);
        @(negedge Clk);
        WriteReg = addr;
        ExtData  = data;
        MuxCtrl  = 1'b0;
        WriteEnb = 1'b1;
        @(posedge Clk);
        #1;
        WriteEnb = 1'b0;
    endtask

    task automatic set_alu(input logic [4:0] ra, input logic [4:0] rb,
                           input logic [3:0] op, input logic [4:0] sh);
        ReadReg1 = ra;
        ReadReg2 = rb;
        AluOp    = op;
        Shamt    = sh;
        #1;
    endtask

    initial begin
        Rst_n    = 1'b0;
        WriteEnb = 1'b0;
        ReadReg1 = 5'd0;
        ReadReg2 = 5'd0;
        WriteReg = 5'd0;
        AluOp    = 4'd0;
        Shamt    = 5'd0;
        MuxCtrl  = 1'b0;
        ExtData  = 32'h1234_5678;
        repeat (3) @(posedge Clk);
        #1;
        set_alu(5'd7, 5'd9, 4'd0, 5'd0);
        chk("rst_rd1", ReadData1, 32'h0);
        chk("rst_rd2", ReadData2, 32'h0);
        chk("rst_result", Result, 32'h0);
        chk("rst_ov", {31'b0, OverFlow}, 32'h0);
        chk("rst_wdata_ext", WriteData, 32'h1234_5678);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Populate registers, then reset mid-run with a coincident write pending.
        write_ext(5'd5, 32'hAAAA_5555);
        write_ext(5'd31, 32'h0BAD_F00D);
        set_alu(5'd5, 5'd31, 4'd0, 5'd0);
        chk("pre_rst_r5", ReadData1, 32'hAAAA_5555);
        chk("pre_rst_r31", ReadData2, 32'h0BAD_F00D);
        @(negedge Clk);
        WriteReg = 5'd5;
        ExtData  = 32'h7777_7777;
        WriteEnb = 1'b1;
        #2;
        Rst_n = 1'b0;
        #1;
        chk("async_rst_r5", ReadData1, 32'h0);
        @(posedge Clk);
        #1;
        chk("rst_prio_r5", ReadData1, 32'h0);
        WriteEnb = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            set_alu(i[4:0], 5'd0, 4'd0, 5'd0);
            chk($sformatf("rst_reg%0d", i), ReadData1, 32'h0);
        end

        // r0 hardwired
        write_ext(5'd0, 32'hDEAD_BEEF);
        set_alu(5'd0, 5'd0, 4'd3, 5'd0);
        chk("r0_rd1", ReadData1, 32'h0);
        chk("r0_rd2", ReadData2, 32'h0);

        // ADD overflow and ALU write-back
        write_ext(5'd1, 32'h7FFF_FFFF);
        write_ext(5'd2, 32'h0000_0001);
        set_alu(5'd1, 5'd2, 4'd0, 5'd0);
        chk("add_result", Result, 32'h8000_0000);
        chk("add_ov", {31'b0, OverFlow}, 32'h1);
        @(negedge Clk);
        MuxCtrl  = 1'b1;
        WriteReg = 5'd3;
        WriteEnb = 1'b1;
        #1;
        chk("wb_wdata", WriteData, 32'h8000_0000);
        @(posedge Clk);
        #1;
        WriteEnb = 1'b0;
        MuxCtrl  = 1'b0;
        set_alu(5'd3, 5'd2, 4'd1, 5'd0);
        chk("wb_r3", ReadData1, 32'h8000_0000);

        // SUB
        chk("sub_ovf_result", Result, 32'h7FFF_FFFF);
        chk("sub_ovf_ov", {31'b0, OverFlow}, 32'h1);
        write_ext(5'd5, 32'd5);
        write_ext(5'd6, 32'd3);
        set_alu(5'd5, 5'd6, 4'd1, 5'd0);
        chk("sub_result", Result, 32'd2);
        chk("sub_ov", {31'b0, OverFlow}, 32'h0);

        // No bypass: old value until the edge
        @(negedge Clk);
        set_alu(5'd1, 5'd4, 4'd0, 5'd0);
        WriteReg = 5'd4;
        ExtData  = 32'h0000_0011;
        WriteEnb = 1'b1;
        #1;
        chk("nobypass_old", ReadData2, 32'h0);
        @(posedge Clk);
        #1;
        WriteEnb = 1'b0;
        chk("nobypass_new", ReadData2, 32'h0000_0011);

        // Logic ops
        write_ext(5'd7, 32'hF0F0_F0F0);
        write_ext(5'd8, 32'h0FF0_0FF0);
        set_alu(5'd7, 5'd8, 4'd2, 5'd0);
        chk("and_result", Result, 32'h00F0_00F0);
        chk("and_ov", {31'b0, OverFlow}, 32'h0);
        set_alu(5'd7, 5'd8, 4'd3, 5'd0);
        chk("or_result", Result, 32'hFFF0_FFF0);
        chk("or_ov", {31'b0, OverFlow}, 32'h0);

        // Shifts: B must be ignored, so point it at a nonzero register
        write_ext(5'd9, 32'h8000_0001);
        set_alu(5'd9, 5'd8, 4'd4, 5'd1);
        chk("sll1", Result, 32'h0000_0002);
        set_alu(5'd9, 5'd8, 4'd5, 5'd1);
        chk("srl1", Result, 32'h4000_0000);
        set_alu(5'd9, 5'd8, 4'd6, 5'd1);
        chk("sra1", Result, 32'hC000_0000);
        set_alu(5'd9, 5'd8, 4'd4, 5'd0);
        chk("sll0", Result, 32'h8000_0001);
        set_alu(5'd9, 5'd8, 4'd5, 5'd0);
        chk("srl0", Result, 32'h8000_0001);
        set_alu(5'd9, 5'd8, 4'd6, 5'd0);
        chk("sra0", Result, 32'h8000_0001);
        set_alu(5'd9, 5'd8, 4'd6, 5'd31);
        chk("sra31", Result, 32'hFFFF_FFFF);
        set_alu(5'd9, 5'd8, 4'd5, 5'd31);
        chk("srl31", Result, 32'h0000_0001);

        // Compares and unused ops
        write_ext(5'd10, 32'hFFFF_FFFF);
        write_ext(5'd11, 32'h0000_0001);
        set_alu(5'd10, 5'd11, 4'd7, 5'd0);
        chk("sgt", Result, 32'h0);
        set_alu(5'd11, 5'd10, 4'd7, 5'd0);
        chk("sgt_rev", Result, 32'h1);
        set_alu(5'd10, 5'd11, 4'd8, 5'd0);
        chk("slt", Result, 32'h1);
        chk("slt_ov", {31'b0, OverFlow}, 32'h0);
        set_alu(5'd10, 5'd11, 4'd9, 5'd3);
        chk("op9", Result, 32'h0);
        set_alu(5'd10, 5'd11, 4'd15, 5'd3);
        chk("op15", Result, 32'h0);
        set_alu(5'd10, 5'd11, 4'd0, 5'd0);
        chk("add_wrap", Result, 32'h0);
        chk("add_wrap_ov", {31'b0, OverFlow}, 32'h0);

        // WriteEnb low holds state
        @(negedge Clk);
        WriteReg = 5'd5;
        ExtData  = 32'h0000_0999;
        WriteEnb = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        set_alu(5'd5, 5'd6, 4'd0, 5'd0);
        chk("we0_hold", ReadData1, 32'd5);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_alu_datapath.md
Name: regfile_alu_datapath

Overview:
Single-cycle MIPS execution-datapath slice: 32x32 register file, 32-bit ALU and a write-back 2:1 mux, wired in a loop. Register-file read ports feed the ALU operands. The mux selects ALU result or external data as the register-file write data. Used as the core of MIPS_single and as a self-contained bring-up block.

Parameters:
DATA_W, 32, datapath width
ADDR_W, 5, register address width (2**ADDR_W registers)
HARDWIRE_R0, 1, when 1 register 0 always reads 0 and ignores writes

Ports:
Clk  in  1  clock, rising edge
Rst_n  in  1  asynchronous active-low reset
WriteEnb  in  1  register write enable
ReadReg1  in  5  read address A
ReadReg2  in  5  read address B
WriteReg  in  5  write address
AluOp  in  4  ALU operation select
Shamt  in  5  shift amount
MuxCtrl  in  1  1: write ALU result; 0: write ExtData
ExtData  in  32  external write data
ReadData1  out  32  register[ReadReg1]
ReadData2  out  32  register[ReadReg2]
Result  out  32  ALU result
OverFlow  out  1  signed overflow flag
WriteData  out  32  mux output presented to the write port

Behaviour:
- Reset: Rst_n low asynchronously clears all registers to 0. Reset has priority over a coincident write.
- Outputs are combinational from register state and inputs, so all outputs read 0 during reset except WriteData, which equals ExtData when MuxCtrl=0.
- Reads: asynchronous, combinational, zero latency.
- Read of a register being written returns the old value until the rising edge, then the new value. No bypass.
- Write: on rising Clk with WriteEnb=1 and Rst_n high, register[WriteReg] <= WriteData.
- WriteEnb=0: register state unchanged.
- HARDWIRE_R0=1: writes to address 0 are dropped and address 0 reads 0.
- Mux: WriteData = MuxCtrl ? Result : ExtData. The write is registered, so no combinational loop exists.
- ALU, with A=ReadData1 and B=ReadData2, purely combinational:
  - 0 ADD: A+B, mod 2^32.
  - 1 SUB: A-B.
  - 2 AND: A&B.
  - 3 OR: A|B.
  - 4 SLL: A<<Shamt, zero fill.
  - 5 SRL: A>>Shamt, zero fill.
  - 6 SRA: A>>>Shamt, sign fill.
  - 7 SGT: Result=1 if $signed(A)>$signed(B), else 0, zero-extended to 32 bits.
  - 8 SLT: Result=1 if $signed(A)<$signed(B), else 0, zero-extended to 32 bits.
  - 9..15: Result=0.
- Shifts use Shamt only; B is ignored. Shamt=0 passes A unchanged.
- OverFlow is valid for ADD and SUB only, and is 0 for every other op.
  - ADD: set when A and B have the same sign and the result sign differs.
  - SUB: set when A and B have different signs and the result sign differs from A.

Decomposition:
- Shared package dp_pkg holds:
  - DATA_W and ADDR_W defaults.
  - ALU opcode localparams: OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_SLL=4, OP_SRL=5, OP_SRA=6, OP_SGT=7, OP_SLT=8.
- One natural sub-module, dp_regfile: reset, storage, two async read ports, one sync write port.
- ALU and mux stay inline in the top as combinational logic.

Test Plan:
- Reset and R0:
  - Assert Rst_n=0 mid-run, then release. All 32 registers read 0.
  - Write 0xDEADBEEF to r0 via ExtData. r0 still reads 0.
- ADD with overflow and write-back:
  - Load via MuxCtrl=0: r1=0x7FFFFFFF, r2=0x00000001.
  - ReadReg1=1, ReadReg2=2, AluOp=0 -> Result=0x80000000, OverFlow=1.
  - MuxCtrl=1, WriteEnb pulse to r3 -> r3 reads 0x80000000.
- SUB with overflow:
  - A=r3 (0x80000000), B=r2 (1), AluOp=1 -> Result=0x7FFFFFFF, OverFlow=1.
  - A=5, B=3 -> Result=2, OverFlow=0.
- Logic ops, with A=0xF0F0F0F0, B=0x0FF00FF0:
  - AND -> 0x00F000F0, OR -> 0xFFF0FFF0.
  - OverFlow=0 for both.
- Shifts, with A=0x80000001 and Shamt=1:
  - SLL -> 0x00000002, SRL -> 0x40000000, SRA -> 0xC0000000.
  - Shamt=0 -> Result equals A for all three.
- Compare and unused ops, with A=0xFFFFFFFF (-1), B=1:
  - SGT -> 0, SLT -> 1.
  - AluOp=9 -> Result=0.
- Write enable: with WriteEnb held 0 across edges, the target register keeps its value.
